iterative_division: RTL



---
 rtl/iterative_division.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/iterative_division.sv
// ============================================================================
//  Module      : iterative_division
//  Description : Multi-cycle unsigned restoring divider. It divides a 2L-bit
//                dividend {dividend_hi, dividend_lo} by an L-bit divisor and
//                produces one quotient bit per clock.
//                Optional macro: DIVISION_FAST_ZERO_EN (skips the iteration
//                loop when the quotient is known to be zero).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module iterative_division #(
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [L-1:0] dividend_hi,
    input  logic [L-1:0] dividend_lo,
    input  logic [L-1:0] divisor,
    output logic [L-1:0] quotient,
    output logic [L-1:0] remainder,
    output logic         busy,
    output logic         valid,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int             CW     = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(L - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    // Partial remainder is held at L bits: after each restore step it is
    // below the divisor, so the extra top bit is always zero between cycles.
    logic [L-1:0]  r_p;
    logic [L-1:0]  r_q;
    logic [L-1:0]  r_divisor;
    logic [CW-1:0] r_count;
    logic [L-1:0]  r_quotient;
    logic [L-1:0]  r_remainder;
    logic          r_div_by_zero;
    logic          r_overflow;

    logic          w_accept;
    logic          w_err_zero;
    logic          w_err_ovf;
    logic          w_fast;
    logic          w_last;
    logic [L:0]    w_p_shift;
    logic [L:0]    w_t;
    logic [L-1:0]  w_p_next;
    logic [L-1:0]  w_q_next;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_err_zero = (divisor == '0);
    assign w_err_ovf  = (dividend_hi >= divisor);
    assign w_last     = (r_count == C_LAST);

`ifdef DIVISION_FAST_ZERO_EN
    // Only reached after the zero-divisor branch, so divisor != 0 here.
    assign w_fast = (dividend_hi == '0) && (dividend_lo < divisor);
`else
    assign w_fast = 1'b0;
`endif

    // One restoring step: shift {P,Q} left, trial-subtract the divisor.
    always_comb begin
        w_p_shift = {r_p, r_q[L-1]};
        w_t       = w_p_shift - {1'b0, r_divisor};
        w_p_next  = w_p_shift[L-1:0];
        w_q_next  = {r_q[L-2:0], 1'b0};
        if (!w_t[L]) begin
            w_p_next = w_t[L-1:0];
            w_q_next = {r_q[L-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err_zero || w_err_ovf || w_fast) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p           <= '0;
            r_q           <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_divisor     <= divisor;
                        r_count       <= '0;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                        if (w_err_zero) begin
                            r_quotient    <= '1;
                            r_remainder   <= dividend_lo;
                            r_div_by_zero <= 1'b1;
                        end else if (w_err_ovf) begin
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_overflow  <= 1'b1;
                        end else if (w_fast) begin
                            r_quotient  <= '0;
                            r_remainder <= dividend_lo;
                        end else begin
                            r_p <= dividend_hi;
                            r_q <= dividend_lo;
                        end
                    end
                end
                S_RUN: begin
                    r_p     <= w_p_next;
                    r_q     <= w_q_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_p_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;
    assign busy        = (r_state != S_IDLE);
    assign valid       = (r_state == S_DONE);

endmodule

`default_nettype wire
